rr_sched: RTL and testbench
===========================

RR_SCHED -- requirements
Module: rr_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 8, datapath data width.
REQ-003 Parameter QUANTUM, default 4, maximum beats per grant (1..15).
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester beat request; bit i belongs to requester i.
REQ-007 req_data  input  NREQ*DW  requester data; slice i is [i*DW +: DW].
REQ-008 ack  output  NREQ  combinational; beat of requester i accepted this cycle.
REQ-009 grant  output  NREQ  registered one-hot current owner; all-zero when no owner.
REQ-010 dp_enable  output  1  registered enable strobe to the shared counter/data-register datapath.
REQ-011 dp_data  output  DW  registered data to the datapath; holds its last value when dp_enable is low.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 beat_total  output  16  registered count of accepted beats; wraps 0xFFFF->0x0000.

Function
REQ-014 The FSM SHALL have states IDLE, SERVE and SWITCH.
REQ-015 IDLE: if any req bit is high, the FSM SHALL latch the round-robin winner into grant and enter SERVE at the next edge; otherwise it stays in IDLE.
REQ-016 The winner SHALL be the first requesting index found scanning from (last+1) mod NREQ upward with wrap, where last is the previous owner.
REQ-017 SERVE: ack[i] SHALL equal grant[i] & req[i]; all other ack bits are 0.
REQ-018 Each cycle with an ack bit high, the next edge SHALL set dp_enable=1, load dp_data from the owner's req_data slice, increment the beat count and increment beat_total.
REQ-019 In cycles with no ack, the next edge SHALL clear dp_enable.
REQ-020 Latency: req asserted in IDLE at cycle 0 -> grant at cycle 1 -> ack at cycle 1 -> dp_enable at cycle 2.
REQ-021 SERVE SHALL exit to SWITCH at the edge where the QUANTUM-th beat is accepted, or at the first edge where the owner's req is low; no beat is accepted in the req-low cycle.
REQ-022 SWITCH SHALL last exactly one cycle with ack=0.
REQ-023 SWITCH SHALL record the owner as last, clear grant and the beat count, and then enter IDLE.
REQ-024 Requests from non-owners during SERVE/SWITCH SHALL be ignored (no ack) and SHALL not be stored; requesters hold req until acked.
REQ-025 A sole persistent requester SHALL be re-granted after the SWITCH and IDLE cycles, giving a 2-cycle gap between quanta.
REQ-026 The beat count width SHALL be 4 bits, and it never exceeds QUANTUM.
REQ-027 Simultaneous requests in IDLE SHALL be resolved only by REQ-016; no fixed priority exists except after reset.

Reset
REQ-028 On reset the FSM SHALL enter IDLE.
REQ-029 On reset grant, ack, dp_enable, busy, the beat count and beat_total SHALL be 0, and dp_data SHALL be 0.
REQ-030 On reset last SHALL be NREQ-1, so requester 0 has first priority.
REQ-031 Reset asserted mid-SERVE SHALL abandon the grant immediately, with no further beats and no dp_enable pulse after release.

Structure
REQ-032 Package rr_sched_pkg SHALL hold the state enum (IDLE/SERVE/SWITCH) and the default constants for NREQ, DW and QUANTUM.
REQ-033 The round-robin selection SHALL be a separate combinational sub-module rr_pick (inputs: req, last; outputs: one-hot winner, valid).

Verification
REQ-034 Reset release, req=0 for 10 cycles -> busy=0, grant=0, dp_enable=0, beat_total=0.
REQ-035 req=4'b1111 held, data i=8'h10+i -> grants 0,1,2,3,0 in order; 4 beats each; dp_data sequence 10,10,10,10,11,...; beat_total=16 after 4 quanta.
REQ-036 req[2] only, held 12 cycles -> beats in 4-beat bursts separated by 2 dead cycles; ack[2] pattern 1111001111.
REQ-037 Owner req[1] drops after 2 beats while req[3]=1 -> SWITCH after beat 2; grant moves to 3; beat_total +2 for requester 1.
REQ-038 Reset asserted during beat 3 of a grant -> all outputs 0 at once; after release, req=4'b1010 -> requester 1 granted first.
REQ-039 beat_total preset near wrap by 65536 accepted beats -> 0xFFFF followed by 0x0000 with no glitch on grant.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared types and default constants for the round-robin scheduler
package rr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam int NREQ_DEFAULT    = 4;
  localparam int DW_DEFAULT      = 8;
  localparam int QUANTUM_DEFAULT = 4;

  // Beat counter is 4 bits, which bounds QUANTUM to 15.
  localparam int BEAT_W  = 4;
  localparam int TOTAL_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
//
// Ports:
//   req     requesting lines, bit i belongs to requester i
//   last    index of the previous owner
//   winner  one-hot first requester found scanning upward from last+1 with wrap
//   valid   high when any requester is present
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  int idx;

  // last itself is checked last (k = NREQ), so a lone previous owner still wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!valid && req[idx[LW-1:0]]) begin
        winner[idx[LW-1:0]] = 1'b1;
        valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sched.sv
// rtl/rr_sched.sv - round-robin beat scheduler feeding a shared datapath
//
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   req           per-requester beat request
//   req_data      requester data, slice i is [i*DW +: DW]
//   ack           combinational beat acceptance (owner only, SERVE only)
//   grant         registered one-hot current owner, zero when no owner
//   dp_enable     registered strobe, one cycle after each accepted beat
//   dp_data       registered data of the last accepted beat
//   busy          high whenever the FSM is not IDLE
//   beat_total    registered wrapping count of accepted beats
module rr_sched
  import rr_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int QUANTUM = QUANTUM_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    grant,
  output logic               dp_enable,
  output logic [DW-1:0]      dp_data,
  output logic               busy,
  output logic [TOTAL_W-1:0] beat_total
);

  localparam int LW = $clog2(NREQ);

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [LW-1:0]     last;
  logic [NREQ-1:0]   winner;
  logic              pick_valid;
  logic [DW-1:0]     owner_data;
  logic [LW-1:0]     owner_idx;
  logic              beat_accept;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .valid  (pick_valid)
  );

  // grant is one-hot, so OR-ing the selected slices is a plain mux.
  always_comb begin
    owner_data = '0;
    owner_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner_data = owner_data | req_data[i*DW +: DW];
        owner_idx  = LW'(i);
      end
    end
  end

  assign ack         = (state == SERVE) ? (grant & req) : '0;
  assign beat_accept = |ack;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      dp_enable  <= 1'b0;
      dp_data    <= '0;
      beat_cnt   <= '0;
      beat_total <= '0;
      last       <= LW'(NREQ - 1);
    end else begin
      dp_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= winner;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (beat_accept) begin
            dp_enable  <= 1'b1;
            dp_data    <= owner_data;
            beat_cnt   <= beat_cnt + 4'd1;
            beat_total <= beat_total + 16'd1;
            if (beat_cnt == BEAT_W'(QUANTUM - 1)) begin
              state <= SWITCH;
            end
          end else begin
            // Owner dropped its request: give up the rest of the quantum.
            state <= SWITCH;
          end
        end
        SWITCH: begin
          last     <= owner_idx;
          grant    <= '0;
          beat_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sched.sv
// tb/tb_rr_sched.sv - table-driven self-checking bench for rr_sched
module tb_rr_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        dp_enable;
  logic [7:0]  dp_data;
  logic        busy;
  logic [15:0] beat_total;

  logic        w_reset;
  logic [1:0]  w_req;
  logic [15:0] w_data;
  logic [1:0]  w_ack;
  logic [1:0]  w_grant;
  logic        w_en;
  logic [7:0]  w_dout;
  logic        w_busy;
  logic [15:0] w_total;

  always #5 clock = ~clock;

  rr_sched #(.NREQ(4), .DW(8), .QUANTUM(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .grant      (grant),
    .dp_enable  (dp_enable),
    .dp_data    (dp_data),
    .busy       (busy),
    .beat_total (beat_total)
  );

  // Long-quantum instance used only for the beat_total wrap run.
  rr_sched #(.NREQ(2), .DW(8), .QUANTUM(15)) w_dut (
    .clock      (clock),
    .reset      (w_reset),
    .req        (w_req),
    .req_data   (w_data),
    .ack        (w_ack),
    .grant      (w_grant),
    .dp_enable  (w_en),
    .dp_data    (w_dout),
    .busy       (w_busy),
    .beat_total (w_total)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        en;
    logic [7:0]  data;
    logic        busy;
    logic [15:0] total;
  } vec_t;

  vec_t tbl[$];

  logic [15:0] prev_t;
  logic [1:0]  prev_g;
  logic        seen_ffff;
  logic        wrap_done;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] ak, input logic [3:0] gr,
                     input logic en, input logic [7:0] d, input logic bz, input logic [15:0] t);
    vec_t v;
    v.rst = rst; v.req = rq; v.ack = ak; v.grant = gr;
    v.en = en; v.data = d; v.busy = bz; v.total = t;
    tbl.push_back(v);
  endtask

  // Called at a falling edge; returns at a later falling edge with reset released.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] ak, input logic [3:0] gr,
                         input logic en, input logic [7:0] d, input logic bz, input logic [15:0] t);
    chk({tag, "_ack"}, idx, 32'(ack), 32'(ak));
    chk({tag, "_grant"}, idx, 32'(grant), 32'(gr));
    chk({tag, "_dp_enable"}, idx, 32'(dp_enable), 32'(en));
    chk({tag, "_dp_data"}, idx, 32'(dp_data), 32'(d));
    chk({tag, "_busy"}, idx, 32'(busy), 32'(bz));
    chk({tag, "_beat_total"}, idx, 32'(beat_total), 32'(t));
  endtask

  initial begin
    req      = 4'b0000;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    w_reset  = 1'b1;
    w_req    = 2'b00;
    w_data   = {8'hB1, 8'hA0};

    // Idle after reset: ten quiet cycles.
    add(1, 4'h0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
    for (int i = 0; i < 9; i++) add(0, 4'h0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);

    // All four requesting: owners 0,1,2,3 each get 4 beats, 6-cycle period.
    for (int q = 0; q < 4; q++) begin
      add(0, 4'hF, 4'h0, 4'h0, 0, (q == 0) ? 8'h00 : 8'(15 + q), 0, 16'(4*q));
      add(0, 4'hF, 4'b0001 << q, 4'b0001 << q, 0, (q == 0) ? 8'h00 : 8'(15 + q), 1, 16'(4*q));
      add(0, 4'hF, 4'b0001 << q, 4'b0001 << q, 1, 8'(16 + q), 1, 16'(4*q + 1));
      add(0, 4'hF, 4'b0001 << q, 4'b0001 << q, 1, 8'(16 + q), 1, 16'(4*q + 2));
      add(0, 4'hF, 4'b0001 << q, 4'b0001 << q, 1, 8'(16 + q), 1, 16'(4*q + 3));
      add(0, 4'hF, 4'h0, 4'b0001 << q, 1, 8'(16 + q), 1, 16'(4*q + 4));
    end
    add(0, 4'hF, 4'h0, 4'h0, 0, 8'h13, 0, 16'd16);
    add(0, 4'hF, 4'h1, 4'h1, 0, 8'h13, 1, 16'd16);

    // Sole requester 2: ack pattern 1111001111 over cycles 1..10.
    add(1, 4'h4, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
    add(0, 4'h4, 4'h4, 4'h4, 0, 8'h00, 1, 16'd0);
    add(0, 4'h4, 4'h4, 4'h4, 1, 8'h12, 1, 16'd1);
    add(0, 4'h4, 4'h4, 4'h4, 1, 8'h12, 1, 16'd2);
    add(0, 4'h4, 4'h4, 4'h4, 1, 8'h12, 1, 16'd3);
    add(0, 4'h4, 4'h0, 4'h4, 1, 8'h12, 1, 16'd4);
    add(0, 4'h4, 4'h0, 4'h0, 0, 8'h12, 0, 16'd4);
    add(0, 4'h4, 4'h4, 4'h4, 0, 8'h12, 1, 16'd4);
    add(0, 4'h4, 4'h4, 4'h4, 1, 8'h12, 1, 16'd5);
    add(0, 4'h4, 4'h4, 4'h4, 1, 8'h12, 1, 16'd6);
    add(0, 4'h4, 4'h4, 4'h4, 1, 8'h12, 1, 16'd7);
    add(0, 4'h4, 4'h0, 4'h4, 1, 8'h12, 1, 16'd8);

    // Owner 1 drops after two beats while 3 waits; grant moves to 3.
    add(1, 4'hA, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
    add(0, 4'hA, 4'h2, 4'h2, 0, 8'h00, 1, 16'd0);
    add(0, 4'hA, 4'h2, 4'h2, 1, 8'h11, 1, 16'd1);
    add(0, 4'h8, 4'h0, 4'h2, 1, 8'h11, 1, 16'd2);
    add(0, 4'h8, 4'h0, 4'h2, 0, 8'h11, 1, 16'd2);
    add(0, 4'h8, 4'h0, 4'h0, 0, 8'h11, 0, 16'd2);
    add(0, 4'h8, 4'h8, 4'h8, 0, 8'h11, 1, 16'd2);
    add(0, 4'h8, 4'h8, 4'h8, 1, 8'h13, 1, 16'd3);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      if (tbl[i].rst) do_reset();
      req = tbl[i].req;
      #1;
      chk_all("vec", i, tbl[i].ack, tbl[i].grant, tbl[i].en, tbl[i].data, tbl[i].busy, tbl[i].total);
    end

    // Reset during beat 3 of a grant, then 1010 must grant requester 1 first.
    @(negedge clock);
    do_reset();
    req = 4'hF;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("beat3_ack", 0, 32'(ack), 32'h1);
    chk("beat3_total", 0, 32'(beat_total), 32'd2);
    reset = 1'b1;
    #1;
    chk_all("rst_now", 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk_all("rst_hold", 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
    reset = 1'b0;
    req   = 4'hA;
    #1;
    chk_all("rel_c0", 0, 4'h0, 4'h0, 0, 8'h00, 0, 16'd0);
    @(negedge clock);
    #1;
    chk_all("rel_c1", 0, 4'h2, 4'h2, 0, 8'h00, 1, 16'd0);
    @(negedge clock);
    #1;
    chk_all("rel_c2", 0, 4'h2, 4'h2, 1, 8'h11, 1, 16'd1);
    req = 4'h0;

    // beat_total wrap: two persistent requesters, 15-beat quanta.
    @(negedge clock);
    w_reset   = 1'b0;
    w_req     = 2'b11;
    prev_t    = 16'h0000;
    prev_g    = 2'b00;
    seen_ffff = 1'b0;
    wrap_done = 1'b0;
    for (int c = 0; c < 80000 && !wrap_done; c++) begin
      @(negedge clock);
      #1;
      if (prev_t == 16'hFFFF && w_total != 16'hFFFF) begin
        chk("wrap_total", c, 32'(w_total), 32'h0);
        chk("wrap_grant_stable", c, 32'(w_grant), 32'(prev_g));
        chk("wrap_grant_onehot", c, 32'($countones(w_grant)), 32'd1);
        wrap_done = 1'b1;
      end
      if (w_total == 16'hFFFF) seen_ffff = 1'b1;
      prev_t = w_total;
      prev_g = w_grant;
    end
    chk("wrap_seen_ffff", 0, 32'(seen_ffff), 32'h1);
    chk("wrap_reached", 0, 32'(wrap_done), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
